ex_muldiv_seq: RTL
==================

// Module: ex_muldiv_seq
// PURPOSE
// Iterative RV32M multiply/divide sequencer beside the EX stage. It takes operands and an M-op from EX
// and runs a radix-2 shift/add (MUL) or restoring shift/subtract (DIV/REM) loop over XLEN cycles.
// It stalls the pipeline while busy and presents a registered result with a one-cycle done pulse.
// The stage control logic selects the result into exResult on that pulse.
// PARAMETERS
// XLEN      32   operand/result width in bits; must equal `BUS_W
// CNT_W     6    iteration counter width; must satisfy 2**CNT_W > XLEN
// PORTS
// clk         in   1      rising-edge clock
// rst         in   1      asynchronous reset, active-high
// start_in    in   1      request from EX; sampled only in IDLE
// op_in       in   3      0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (funct3)
// srcA_in     in   XLEN   rs1 operand; sampled with start_in
// srcB_in     in   XLEN   rs2 operand; sampled with start_in
// flush_in    in   1      abort current op (branch/trap flush)
// busy_out    out  1      registered; high in CALC, FIX and DONE
// stall_out   out  1      combinational; (IDLE & start_in & ~flush_in) | CALC | FIX
// done_out    out  1      registered; single-cycle pulse, result_out valid
// result_out  out  XLEN   registered result; holds until next accepted start
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; busy_out=0; done_out=0; result_out=0; counter=0; acc/quot=0.
// - States: IDLE, CALC, FIX, DONE.
// - IDLE: start_in & ~flush_in accepts the op at edge E0.
//   - Latch op and operand magnitudes; record signs.
//   - Signed treatment: MULH/DIV/REM both operands; MULHSU rs1 only.
//   - Special cases go IDLE->DONE directly:
//     - Divide by zero (B==0): quotient=all ones, remainder=A.
//     - Signed overflow (DIV/REM, A=0x8000_0000, B=all ones): quotient=A, remainder=0.
//     - Special-case latency: done_out high in cycle after E0.
//   - Otherwise IDLE->CALC with counter=0.
// - CALC: one iteration per cycle over a 2*XLEN-bit product or remainder:quotient register.
//   - Counter increments each cycle; after XLEN iterations (counter==XLEN-1) go to FIX.
// - FIX: one cycle.
//   - Negate for signed ops: product if signs differ; quotient if signs differ; remainder takes dividend sign.
//   - Select output: low word (MUL), high word (MULH*), quotient (DIV*) or remainder (REM*).
//   - Write the selected word to result_out. FIX->DONE.
// - DONE: done_out=1 for exactly this cycle; stall_out=0 so EX captures. DONE->IDLE unconditionally.
//   - start_in in DONE is ignored; EX re-issues it in the following IDLE cycle.
// - Normal latency: done_out asserted XLEN+2 cycles after E0 (34 for XLEN=32).
// - start_in in CALC/FIX is ignored; operands are not re-sampled.
// - flush_in:
//   - In any non-IDLE state: next state IDLE, done_out=0, result_out unchanged.
//   - Takes priority over start_in in the same cycle.
// - All arithmetic is modulo 2**XLEN on the result word. No X propagation from unused op_in codes.
// TESTING
// 1. MULHU 0xFFFF_FFFF * 0xFFFF_FFFF -> done at E0+34, result 0xFFFF_FFFE; MUL same operands -> 0x0000_0001.
// 2. DIV -7 / 2 -> quotient 0xFFFF_FFFD (-3); REM -7 / 2 -> 0xFFFF_FFFF (-1); both at E0+34.
// 3. DIVU 5 / 0 -> 0xFFFF_FFFF and REM 5 / 0 -> 5, done at E0+1; DIV 0x8000_0000 / -1 -> 0x8000_0000, REM -> 0.
// 4. flush_in at E0+10 of MUL 3*4 -> state IDLE at E0+11, no done_out, result_out keeps prior value, stall_out=0.
// 5. Assert rst at E0+5 mid-DIV -> all outputs 0 immediately (async); after release, MULHSU -1 * 2 -> 0xFFFF_FFFF.
// 6. start_in held high through a whole op -> exactly one done pulse, next op accepted in the IDLE cycle after DONE.

Source files
------------

// File: rtl/ex_muldiv_seq.sv
// ---------------------------------------------------------------------------
// ex_muldiv_seq
//
// Iterative RV32M multiply/divide unit that sits beside the EX stage.
// MUL* ops use a radix-2 shift/add loop and DIV*/REM* ops use a restoring
// shift/subtract loop. Each loop runs XLEN iterations over a 2*XLEN-bit
// working register. Operands are reduced to magnitudes on entry, and the
// sign is put back in a single FIX cycle. While the unit is working it
// stalls the pipeline. The result is registered and is marked by a
// one-cycle done pulse.
//
// Divide-by-zero and signed overflow are resolved directly at acceptance.
// These cases skip the loop and reach DONE one cycle after the op is taken.
//
// XLEN must match the pipeline data-bus width.
//
// Ports
//   clk         in   1     rising-edge clock
//   rst         in   1     asynchronous reset, active-high
//   start_in    in   1     op request from EX (sampled only in IDLE)
//   op_in       in   3     funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   srcA_in     in   XLEN  rs1 operand (sampled with start_in)
//   srcB_in     in   XLEN  rs2 operand (sampled with start_in)
//   flush_in    in   1     abort the current op
//   busy_out    out  1     registered; high in CALC, FIX and DONE
//   stall_out   out  1     combinational pipeline stall
//   done_out    out  1     registered one-cycle pulse, result_out valid
//   result_out  out  XLEN  registered result, held until replaced
// ---------------------------------------------------------------------------
module ex_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] srcA_in,
  input  logic [XLEN-1:0] srcB_in,
  input  logic            flush_in,
  output logic            busy_out,
  output logic            stall_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [2*XLEN-1:0]   acc_reg, acc_next;    // product, or remainder:quotient
  logic [XLEN-1:0]     opnd_reg, opnd_next;  // |multiplicand| or |divisor|
  logic [2:0]          op_reg, op_next;
  logic                sa_reg, sa_next;      // rs1 was negative (signed view)
  logic                sb_reg, sb_next;      // rs2 was negative (signed view)
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic [XLEN-1:0]     result_reg, result_next;

  // ---------------- operand decode at acceptance ----------------
  logic            accept;
  logic            signed_a_in, signed_b_in;
  logic            neg_a_in, neg_b_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  logic            div_zero_in, div_ovf_in, special_in;
  logic [XLEN-1:0] special_val;

  always_comb begin
    accept      = (state_reg == S_IDLE) && start_in && !flush_in;
    // MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 only.
    signed_a_in = (op_in == 3'd1) || (op_in == 3'd2) || (op_in == 3'd4) || (op_in == 3'd6);
    signed_b_in = (op_in == 3'd1) || (op_in == 3'd4) || (op_in == 3'd6);
    neg_a_in    = signed_a_in && srcA_in[XLEN-1];
    neg_b_in    = signed_b_in && srcB_in[XLEN-1];
    a_mag_in    = neg_a_in ? -srcA_in : srcA_in;
    b_mag_in    = neg_b_in ? -srcB_in : srcB_in;
    div_zero_in = op_in[2] && (srcB_in == '0);
    // Only the signed forms (DIV, REM have op_in[0]==0) can overflow.
    div_ovf_in  = op_in[2] && !op_in[0] && (srcA_in == MIN_NEG) && (&srcB_in);
    special_in  = div_zero_in || div_ovf_in;
    // op_in[1] distinguishes REM* from DIV*.
    if (div_zero_in) begin
      special_val = op_in[1] ? srcA_in : '1;
    end else begin
      special_val = op_in[1] ? '0 : srcA_in;
    end
  end

  // ---------------- one loop iteration ----------------
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     rs_shift;
  logic [XLEN:0]     rs_diff;
  logic              rs_ge;
  logic [2*XLEN-1:0] div_step;

  always_comb begin
    // Multiply: the multiplier sits in the low half and its LSB decides
    // whether the multiplicand is added into the high half. The carry is
    // kept, then the whole register shifts right.
    add_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, opnd_reg};
    mul_step = acc_reg[0] ? {add_sum, acc_reg[XLEN-1:1]}
                          : {1'b0, acc_reg[2*XLEN-1:1]};
    // Divide: shift the next dividend bit into the partial remainder and
    // subtract the divisor when it fits. The quotient bit enters at the LSB.
    rs_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    rs_ge    = (rs_shift >= {1'b0, opnd_reg});
    rs_diff  = rs_shift - {1'b0, opnd_reg};
    div_step = rs_ge ? {rs_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1}
                     : {rs_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
  end

  // ---------------- sign fix-up and result select ----------------
  logic              neg_res;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_word;

  always_comb begin
    neg_res  = sa_reg ^ sb_reg;
    prod_fix = neg_res ? -acc_reg : acc_reg;
    quot_fix = neg_res ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    // The remainder always takes the sign of the dividend.
    rem_fix  = sa_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    case (op_reg)
      3'd0:                fix_word = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_word = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_word = quot_fix;
      default:             fix_word = rem_fix;
    endcase
  end

  // ---------------- next-state / datapath control ----------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    opnd_next   = opnd_reg;
    op_next     = op_reg;
    sa_next     = sa_reg;
    sb_next     = sb_reg;
    result_next = result_reg;

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          op_next = op_in;
          sa_next = neg_a_in;
          sb_next = neg_b_in;
          if (special_in) begin
            result_next = special_val;
            state_next  = S_DONE;
          end else begin
            cnt_next   = '0;
            // MUL: multiplier |B| in the low half, |A| is added.
            // DIV: dividend |A| in the low half, |B| is the divisor.
            acc_next   = op_in[2] ? {{XLEN{1'b0}}, a_mag_in} : {{XLEN{1'b0}}, b_mag_in};
            opnd_next  = op_in[2] ? b_mag_in : a_mag_in;
            state_next = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_next = op_reg[2] ? div_step : mul_step;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(XLEN-1)) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        result_next = fix_word;
        state_next  = S_DONE;
      end
      S_DONE: begin
        // A start_in seen here is ignored. EX re-presents it in IDLE.
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Flush abandons the op from any active state and leaves the last
    // result untouched.
    if (flush_in && (state_reg != S_IDLE)) begin
      state_next  = S_IDLE;
      result_next = result_reg;
    end

    busy_next = (state_next != S_IDLE);
    done_next = (state_next == S_DONE);
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      op_reg     <= '0;
      sa_reg     <= 1'b0;
      sb_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      opnd_reg   <= opnd_next;
      op_reg     <= op_next;
      sa_reg     <= sa_next;
      sb_reg     <= sb_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      result_reg <= result_next;
    end
  end

  assign busy_out   = busy_reg;
  assign done_out   = done_reg;
  assign result_out = result_reg;
  assign stall_out  = ((state_reg == S_IDLE) && start_in && !flush_in) ||
                      (state_reg == S_CALC) || (state_reg == S_FIX);

endmodule
